// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving one shared valid/ready channel.
// A grant is kept while its owner keeps sending beats, and is handed to the
// other requester after MAX_HOLD accepted beats if the other side is waiting.
module mux2_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sel
);

    localparam int unsigned      CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;       // 0 = A was granted last, 1 = B
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             enter_a;
    logic             enter_b;
    logic             at_limit;
    logic [CNT_W-1:0] hold_inc;

    // The beat being accepted now is the MAX_HOLD-th one (or later, once the
    // counter has saturated while the other side was idle): a waiting
    // requester takes over on the next edge.
    assign at_limit = (hold_cnt_q >= HOLD_LAST);
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

    // State register plus the grant bookkeeping that travels with it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;             // A wins the first tie
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, hand-over and hold counting in GNT_*.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        enter_a    = 1'b0;
        enter_b    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_q)) begin
                    enter_a = 1'b1;
                end else if (req_b) begin
                    enter_b = 1'b1;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    if (req_b) enter_b = 1'b1;
                    else       state_d = IDLE;
                end else if (out_ready) begin
                    if (req_b && at_limit) enter_b = 1'b1;
                    else                   hold_cnt_d = hold_inc;
                end
                // req_a high with out_ready low: stalled, nothing moves
            end
            GNT_B: begin
                if (!req_b) begin
                    if (req_a) enter_a = 1'b1;
                    else       state_d = IDLE;
                end else if (out_ready) begin
                    if (req_a && at_limit) enter_a = 1'b1;
                    else                   hold_cnt_d = hold_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh grant always starts with the mux pointed at its owner and
        // an empty beat count.
        if (enter_a) begin
            state_d    = GNT_A;
            sel_d      = 1'b0;
            last_d     = 1'b0;
            hold_cnt_d = '0;
        end else if (enter_b) begin
            state_d    = GNT_B;
            sel_d      = 1'b1;
            last_d     = 1'b1;
            hold_cnt_d = '0;
        end
    end

    // Output decode: the channel is valid only while the granted side requests.
    always_comb begin
        out_valid = ((state_q == GNT_A) && req_a) || ((state_q == GNT_B) && req_b);
        ack_a     = (state_q == GNT_A) && req_a && out_ready;
        ack_b     = (state_q == GNT_B) && req_b && out_ready;
        sel       = sel_q;
        out_data  = sel_q ? data_b : data_a;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter (WIDTH=8, MAX_HOLD=4) followed by a
// protocol-respecting random phase checking the ack/valid invariants.
module tb_mux2_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic [7:0] data_a;
    logic       ack_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       ack_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       sel;

    int tests;
    int fails;

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .data_a   (data_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .ack_b    (ack_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle's drive point, just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic a_acked;
        logic b_acked;

        tests     = 0;
        fails     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        data_a    = 8'h11;
        data_b    = 8'h22;
        out_ready = 1'b1;

        // Reset holds outputs quiet even with both requests and ready high
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_sel", sel, 0);
        next_cycle();
        apply_reset();

        // Single A beat: one IDLE cycle of arbitration, then accepted
        req_a = 1'b1; data_a = 8'h5A; out_ready = 1'b1;
        @(negedge clk);
        check("a1_idle_valid", out_valid, 0);
        check("a1_idle_ack", ack_a, 0);
        next_cycle();
        @(negedge clk);
        check("a1_valid", out_valid, 1);
        check("a1_sel", sel, 0);
        check("a1_data", out_data, 8'h5A);
        check("a1_ack_a", ack_a, 1);
        check("a1_ack_b", ack_b, 0);
        next_cycle();
        req_a = 1'b0;
        @(negedge clk);
        check("a1_drop_valid", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("a1_idle2_valid", out_valid, 0);
        check("a1_idle2_sel", sel, 0);
        next_cycle();

        // Both requesting from reset: 4 to A, 4 to B, back to A, no gaps
        apply_reset();
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 8'hA0; data_b = 8'hB0;
        @(negedge clk);
        check("rr_idle_valid", out_valid, 0);
        next_cycle();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("rr_valid_%0d", i), out_valid, 1);
            check($sformatf("rr_ack_a_%0d", i), ack_a, (i < 4 || i == 8) ? 1 : 0);
            check($sformatf("rr_ack_b_%0d", i), ack_b, (i >= 4 && i < 8) ? 1 : 0);
            check($sformatf("rr_data_%0d", i), out_data, (i >= 4 && i < 8) ? 8'hB0 : 8'hA0);
            next_cycle();
        end

        // A withdraws while B waits: hand-over, then B stalled by out_ready
        req_a = 1'b0; req_b = 1'b1; data_b = 8'hC3; out_ready = 1'b0;
        @(negedge clk);
        check("stall_handover_valid", out_valid, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_valid_%0d", i), out_valid, 1);
            check($sformatf("stall_ack_b_%0d", i), ack_b, 0);
            check($sformatf("stall_data_%0d", i), out_data, 8'hC3);
            check($sformatf("stall_sel_%0d", i), sel, 1);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ack_b", ack_b, 1);
        next_cycle();
        req_b = 1'b0;
        @(negedge clk);
        check("b_drop_valid", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("b_idle_valid", out_valid, 0);
        check("b_idle_sel", sel, 1);
        next_cycle();

        // A alone for 10 beats: the hold limit never forces a switch
        req_a = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("hold_idle_valid", out_valid, 0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            data_a = 8'(i + 1);
            @(negedge clk);
            check($sformatf("hold_ack_a_%0d", i), ack_a, 1);
            check($sformatf("hold_ack_b_%0d", i), ack_b, 0);
            check($sformatf("hold_sel_%0d", i), sel, 0);
            check($sformatf("hold_data_%0d", i), out_data, 8'(i + 1));
            next_cycle();
        end
        req_a = 1'b0;
        @(negedge clk);
        check("hold_drop_valid", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("hold_idle_valid2", out_valid, 0);
        check("hold_idle_sel", sel, 0);
        next_cycle();

        // Mid-grant reset: outputs drop at once, A wins the tie afterwards
        // even though A held the last grant before reset
        req_a = 1'b1; out_ready = 1'b1; data_a = 8'h77;
        @(negedge clk);
        check("mr_idle_valid", out_valid, 0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("mr_ack_a_%0d", i), ack_a, 1);
            next_cycle();
        end
        @(negedge clk);
        check("mr_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", out_valid, 0);
        check("mr_async_ack_a", ack_a, 0);
        req_b = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_post_idle_valid", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("mr_post_ack_a", ack_a, 1);
        check("mr_post_ack_b", ack_b, 0);
        check("mr_post_sel", sel, 0);
        next_cycle();

        // Random traffic that honours the hold-until-ack protocol
        apply_reset();
        a_acked = 1'b0;
        b_acked = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!req_a || a_acked) begin
                req_a  = 1'($urandom_range(0, 1));
                data_a = 8'($urandom);
            end
            if (!req_b || b_acked) begin
                req_b  = 1'($urandom_range(0, 1));
                data_b = 8'($urandom);
            end
            @(negedge clk);
            check("rnd_ack_exclusive", {31'd0, ack_a & ack_b}, 0);
            check("rnd_ack_needs_valid", {31'd0, (ack_a | ack_b) & ~out_valid}, 0);
            a_acked = ack_a;
            b_acked = ack_b;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
